uart_rx_monitor: RTL
====================

UART_RX_MONITOR -- requirements
Module: uart_rx_monitor

Interface
REQ-001 SHALL have parameter CLK_DIV, default 868, clocks per UART bit (100 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal values 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, capture FIFO entries; power of 2, 2..256.
REQ-006 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port rx  input  1  asynchronous serial line, idle high (the DUT uart_TX).
REQ-009 SHALL have port out_ready  input  1  consumer accepts the head entry when high with out_valid.
REQ-010 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port out_data  output  8  head byte, LSB-aligned, upper (8-DATA_BITS) bits zero.
REQ-012 SHALL have port out_perr  output  1  parity-error flag stored with the head byte; 0 when PARITY=0.
REQ-013 SHALL have port count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 SHALL have port overflow  output  1  sticky; set when a good frame is dropped because the FIFO is full.
REQ-015 SHALL have port frame_errs  output  16  saturating count of frames with a low stop bit.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer; all sampling uses the synchronized value rx_s.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PAR, STOP, driven by a bit-timer counter and a bit index.
REQ-018 IDLE: on rx_s==0, go to START and load the timer with CLK_DIV/2 - 1 (integer division).
REQ-019 START: at timer expiry, sample rx_s; 1 -> false start, back to IDLE, nothing recorded; 0 -> DATA, timer loaded with CLK_DIV-1.
REQ-020 DATA: sample at each timer expiry, LSB first, DATA_BITS samples; then PAR if PARITY!=0, else STOP.
REQ-021 PAR: one sample; perr=1 if the XOR of data bits and the parity bit is 0 for odd, or 1 for even.
REQ-022 STOP: STOP_BITS samples; any low sample marks a framing error.
REQ-023 Frame end, good stop: push {perr,data} in the cycle after the last stop sample; return to IDLE in the same cycle.
REQ-024 Frame end, framing error: no push; frame_errs increments (saturates at 0xFFFF); after the stop phase, wait in IDLE for rx_s==1 before re-arming start detection.
REQ-025 Successive sample points within a frame SHALL be exactly CLK_DIV clocks apart.
REQ-026 Pop occurs when out_valid && out_ready; out_data/out_perr show the new head on the next cycle.
REQ-027 Push while full with no pop: entry dropped, overflow set; it stays set until reset.
REQ-028 Push and pop in the same cycle while full: both succeed; count unchanged; overflow not set.
REQ-029 Push and pop in the same cycle while empty: push only; out_valid=1 next cycle.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL equal pushes minus pops at all times.
REQ-031 rx activity SHALL NOT be lost while the consumer stalls; the FSM never waits on out_ready.

Reset
REQ-032 reset SHALL force FSM=IDLE, timer=0, bit index=0, synchronizer flops=1, FIFO empty, count=0, out_valid=0, out_data=0, out_perr=0, overflow=0, frame_errs=0.
REQ-033 reset mid-frame SHALL abandon the frame with no push; reception restarts at the next falling edge after reset is released.
REQ-034 reset has priority over every simultaneous push, pop or sample.

Verification
REQ-035 CLK_DIV=16, 8N1, send 0x55 with out_ready=0 -> out_valid=1, out_data=0x55, out_perr=0, count=1, all within 3 clocks after the stop-bit midpoint.
REQ-036 PARITY=2, send 0xA3 with parity bit 1 -> entry 0xA3 with out_perr=1; resend with parity bit 0 -> out_perr=0.
REQ-037 Send 0x41 with stop bit driven low -> no entry; frame_errs=1; next frame 0x42 is received correctly after the line returns high.
REQ-038 rx low pulse of 4 clocks (CLK_DIV=16) -> false start; count=0; FSM back in IDLE.
REQ-039 FIFO_DEPTH=4, out_ready=0, send 5 bytes 0x01..0x05 -> count=4, overflow=1; drain yields 0x01..0x04 in order.
REQ-040 Assert reset during DATA of 0x7E, then send 0x33 -> only 0x33 captured; frame_errs=0.

Source files
------------

// File: rtl/uart_rx_monitor.sv
`timescale 1ns/1ps
// uart_rx_monitor
//    Passive UART receiver that captures frames from a DUT's TX line into a
//    small FIFO for a consumer to drain at its own pace.
//
//    Ports
//       clock       sole clock, rising edge
//       reset       synchronous, active high
//       rx          asynchronous serial line, idle high
//       out_ready   consumer accepts head entry when high with out_valid
//       out_valid   FIFO non-empty
//       out_data    head byte, LSB aligned, unused upper bits zero
//       out_perr    parity-error flag stored with the head byte
//       count       FIFO occupancy
//       overflow    sticky, a good frame was dropped on a full FIFO
//       frame_errs  saturating count of frames with a low stop bit
//
//    state   | meaning
//    --------+----------------------------------------------------------
//    S_IDLE  | waiting for a falling edge (or for line high after a
//            | framing error)
//    S_START | half a bit into the start bit, confirm it is still low
//    S_DATA  | sampling DATA_BITS data bits, LSB first
//    S_PAR   | sampling the parity bit
//    S_STOP  | sampling STOP_BITS stop bits
module uart_rx_monitor #(
   parameter int CLK_DIV    = 868,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          rx,
   input  logic                          out_ready,
   output logic                          out_valid,
   output logic [7:0]                    out_data,
   output logic                          out_perr,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overflow,
   output logic [15:0]                   frame_errs
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [15:0] TMR_HALF  = 16'(CLK_DIV / 2 - 1);
   localparam logic [15:0] TMR_FULL  = 16'(CLK_DIV - 1);
   localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
   localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   state_t        state, next_state;
   logic          rx_meta, rx_s;
   logic [15:0]   timer;
   logic [2:0]    bit_idx;
   logic [7:0]    data_sh;
   logic          perr_q, ferr_q, wait_high;
   logic          push_pend;
   logic [8:0]    push_word;
   logic [8:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;

   logic tmr_done, start_det, shift_en, par_en, stop_en, last_data, last_stop;
   logic full, do_push, do_pop;

   assign tmr_done  = (timer == 16'd0);
   assign last_data = shift_en && (bit_idx == LAST_DATA);
   assign last_stop = stop_en && (bit_idx == LAST_STOP);

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (start_det) next_state = S_START;
         S_START: if (tmr_done)  next_state = rx_s ? S_IDLE : S_DATA;
         S_DATA:  if (last_data) next_state = (PARITY != 0) ? S_PAR : S_STOP;
         S_PAR:   if (tmr_done)  next_state = S_STOP;
         S_STOP:  if (last_stop) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      start_det = 1'b0;
      shift_en  = 1'b0;
      par_en    = 1'b0;
      stop_en   = 1'b0;
      case (state)
         S_IDLE:  start_det = !wait_high && !rx_s;
         S_DATA:  shift_en  = tmr_done;
         S_PAR:   par_en    = tmr_done;
         S_STOP:  stop_en   = tmr_done;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta    <= 1'b1;
         rx_s       <= 1'b1;
         timer      <= 16'd0;
         bit_idx    <= 3'd0;
         data_sh    <= 8'd0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         wait_high  <= 1'b0;
         push_pend  <= 1'b0;
         push_word  <= 9'd0;
         frame_errs <= 16'd0;
      end else begin
         rx_meta   <= rx;
         rx_s      <= rx_meta;
         push_pend <= 1'b0;

         // Reloading on every expiry keeps sample points exactly CLK_DIV apart.
         if (start_det)            timer <= TMR_HALF;
         else if (state == S_IDLE) timer <= 16'd0;
         else if (tmr_done)        timer <= TMR_FULL;
         else                      timer <= timer - 16'd1;

         if (start_det) begin
            bit_idx <= 3'd0;
            data_sh <= 8'd0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
         end
         if (shift_en) begin
            data_sh[bit_idx] <= rx_s;
            bit_idx          <= last_data ? 3'd0 : bit_idx + 3'd1;
         end
         if (par_en) begin
            if (PARITY == 1) perr_q <= ~(^data_sh ^ rx_s);
            else             perr_q <= ^data_sh ^ rx_s;
         end
         if (stop_en) begin
            bit_idx <= bit_idx + 3'd1;
            if (!rx_s) ferr_q <= 1'b1;
         end
         if (last_stop) begin
            if (ferr_q || !rx_s) begin
               // A line stuck low must not be mistaken for a new start bit.
               wait_high <= 1'b1;
               if (frame_errs != 16'hFFFF) frame_errs <= frame_errs + 16'd1;
            end else begin
               push_pend <= 1'b1;
               push_word <= {perr_q, data_sh};
            end
         end
         if (state == S_IDLE && rx_s) wait_high <= 1'b0;
      end
   end

   assign full    = (count == FULL_CNT);
   assign do_pop  = out_valid && out_ready;
   assign do_push = push_pend && (!full || do_pop);

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_word;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + (AW+1)'(1);
         else if (!do_push && do_pop) count <= count - (AW+1)'(1);
         if (push_pend && full && !do_pop) overflow <= 1'b1;
      end
   end

   assign out_valid = (count != '0);
   assign out_data  = out_valid ? mem[rd_ptr][7:0] : 8'h00;
   assign out_perr  = out_valid ? mem[rd_ptr][8]   : 1'b0;

endmodule
